serial_mul_sched: RTL and testbench
===================================

Name: serial_mul_sched

Overview:
Two-requester scheduler and sequencer for the team's bit-serial W-bit multiplier (CLK/RST/A/B/O style datapath). It accepts parallel operand pairs from two clients via valid/ready and arbitrates between them round-robin. It clears the serial multiplier, shifts operands in LSB-first, and collects the 2W-bit serial product. The tagged product is returned on a valid/ready result port.

Parameters:
W, 4, operand width in bits; product is 2W bits
LAT, 1, cycles from first operand bit on mul_a/mul_b to product bit 0 on mul_o (0..3)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
req_valid  input  2  bit i: requester i has an operand pair
req_ready  output  2  bit i: requester i accepted this cycle (one-hot or zero)
req_a  input  2*W  {a1, a0} multiplicands
req_b  input  2*W  {b1, b0} multipliers
mul_clr  output  1  clear pulse to serial multiplier state
mul_a  output  1  serial multiplicand bit, LSB first
mul_b  output  1  serial multiplier bit, LSB first
mul_o  input  1  serial product bit from multiplier
res_valid  output  1  product available
res_ready  input  1  consumer takes product
res_data  output  2*W  unsigned product
res_id  output  1  requester index of res_data
busy  output  1  high in any state except IDLE

Behaviour:
- Reset:
  - state=IDLE, last_grant=1 (so requester 0 wins first), counter=0.
  - res_valid=0, res_data=0, res_id=0, mul_clr=0, mul_a=0, mul_b=0, req_ready=0, busy=0.
- FSM states: IDLE, CLR, SHIFT, DONE.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester not equal to last_grant.
  - req_ready is high only for the granted bit, and only in IDLE.
  - On the accept edge, capture a, b and id; set last_grant=id; go to CLR.
  - No request valid: stay in IDLE, all outputs 0.
- CLR (1 cycle): mul_clr=1, mul_a=mul_b=0; go to SHIFT with counter=0.
- SHIFT (2W+LAT cycles, counter t=0..2W+LAT-1):
  - For t<W: mul_a=a[t], mul_b=b[t]. For t>=W: mul_a=mul_b=0.
  - For t>=LAT: sample mul_o into product bit t-LAT at the end of cycle t.
  - After t=2W+LAT-1, go to DONE.
- DONE:
  - res_valid=1; res_data and res_id stay stable until res_ready is seen high at a rising edge.
  - On the handshake edge, go to IDLE. The next accept happens at the earliest one cycle later (no accept in the same cycle as the result handshake).
- Latency: res_valid rises on the (2W+LAT+1)th rising edge after the accept edge; for W=4, LAT=1 that is the 10th edge.
- Output timing:
  - mul_clr, mul_a, mul_b, res_* and busy are functions of registered state only; no combinational path from mul_o or res_ready.
  - req_ready depends combinationally on req_valid (grant logic) only.
- Requests that arrive while busy wait. req_valid must be held by the client until req_ready; operands are don't-care after the accept edge.
- RST asserted mid-operation (any state): the next edge returns to IDLE. The partial product is discarded and res_valid=0; last_grant resets to 1.
- Arithmetic: unsigned; 2W-bit result, no overflow possible.
- res_data is not cleared on the return to IDLE. It holds the last product until the next DONE, with the new value loaded as res_valid rises.

Test Plan:
Test environment: a behavioural serial multiplier model with LAT=1. It clears on mul_clr and drives product bit k on mul_o during SHIFT cycle k+1.
1. Single request: req_valid=01, a0=3, b0=5.
   - req_ready=01 for one cycle.
   - mul_clr pulses once, then mul_a=1,1,0,0,0,0,0,0,0.
   - res_valid rises on the 10th edge after accept with res_data=15, res_id=0.
2. Simultaneous requests after reset: a0=15, b0=15, a1=7, b1=9 held valid.
   - First result: id=0, data=225. Second result: id=1, data=63.
   - busy stays high during each operation.
3. Fairness: requester 1 always valid, requester 0 re-asserts after each result.
   - Grants alternate 0,1,0,1; no requester is granted twice in a row while the other is waiting.
4. Back-pressure: res_ready=0 for 5 cycles in DONE with a new req_valid=10 pending.
   - res_valid, res_data and res_id stay stable; req_ready=00 throughout.
   - Accept of the new request occurs one cycle after the handshake.
5. Reset mid-SHIFT (t=3): RST high for one cycle.
   - Next cycle: IDLE, busy=0, res_valid=0.
   - A new request a0=2, b0=6 then yields 12, unaffected by the aborted operation.
6. Edge operands: a=0, b=15 gives res_data=0; a=15, b=1 gives res_data=15; mul_o is sampled exactly for t=1..8.

Source files
------------

// File: rtl/serial_mul_sched.sv
// Round-robin scheduler and sequencer for a bit-serial W x W multiplier.
// Accepts operand pairs from two requesters and returns a tagged 2W-bit product.
module serial_mul_sched #(
   parameter int W   = 4,
   parameter int LAT = 1
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   output logic           mul_clr,
   output logic           mul_a,
   output logic           mul_b,
   input  logic           mul_o,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [2*W-1:0] res_data,
   output logic           res_id,
   output logic           busy
);

   localparam int NSHIFT = 2*W + LAT;
   localparam int CW     = $clog2(NSHIFT + 1);

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

   state_t         state, state_nxt;
   logic           last_grant;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   a_sh, b_sh;
   logic [2*W-1:0] prod;
   logic           id_r;
   logic [1:0]     grant;
   logic           shift_last;

   // With both requesters valid, the one that did not win last time goes next.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready  = (state == IDLE) ? grant : 2'b00;
   assign shift_last = (cnt == CW'(NSHIFT - 1));

   assign mul_clr   = (state == CLR);
   assign mul_a     = (state == SHIFT) & a_sh[0];
   assign mul_b     = (state == SHIFT) & b_sh[0];
   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|grant)     state_nxt = CLR;
         CLR:                     state_nxt = SHIFT;
         SHIFT:   if (shift_last) state_nxt = DONE;
         DONE:    if (res_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Operands shift out LSB first and run dry after W cycles, so the serial
   // lines drop to zero by themselves; product bits shift in from the top.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_grant <= 1'b1;
         cnt        <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         prod       <= '0;
         id_r       <= 1'b0;
         res_data   <= '0;
         res_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  a_sh       <= grant[1] ? req_a[2*W-1:W] : req_a[W-1:0];
                  b_sh       <= grant[1] ? req_b[2*W-1:W] : req_b[W-1:0];
                  id_r       <= grant[1];
                  last_grant <= grant[1];
               end
            end
            CLR: begin
               cnt  <= '0;
               prod <= '0;
            end
            SHIFT: begin
               cnt  <= cnt + 1'b1;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               if (cnt >= CW'(LAT)) prod <= {mul_o, prod[2*W-1:1]};
               if (shift_last) begin
                  res_data <= {mul_o, prod[2*W-1:1]};
                  res_id   <= id_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mul_sched.sv
// Self-checking bench for serial_mul_sched with a behavioural LAT=1 serial
// multiplier, directed vector table, hand sequences and a random scoreboard.
module tb_serial_mul_sched;

   localparam int W     = 4;
   localparam int LAT   = 1;
   localparam int NRAND = 30;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [7:0] req_a = 8'd0, req_b = 8'd0;
   logic       res_ready = 1'b0;
   logic       mul_o = 1'b0;
   logic [1:0] req_ready;
   logic       mul_clr, mul_a, mul_b, res_valid, res_id, busy;
   logic [7:0] res_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   serial_mul_sched #(.W(W), .LAT(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_clr(mul_clr), .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .busy(busy)
   );

   // Serial multiplier: collects operand bits, drives product bit k during
   // the cycle after it received operand bit k, and drives 1 outside that window.
   logic [15:0] ma, mb, pm;
   int          mk = 100;
   always @(posedge CLK) begin
      if (mul_clr) begin
         ma = 16'd0; mb = 16'd0; mk = 0;
         mul_o <= 1'b1;
      end else if (mk < 2*W) begin
         ma[mk] = mul_a;
         mb[mk] = mul_b;
         pm = ma * mb;
         mul_o <= pm[mk];
         mk++;
      end else begin
         mul_o <= 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
      tick(); tick();
      RST = 1'b0;
   endtask

   task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
      if (id == 0) begin req_a[3:0] = a; req_b[3:0] = b; end
      else         begin req_a[7:4] = a; req_b[7:4] = b; end
   endtask

   task automatic wait_ready(input int id, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         #1;
         if (req_ready[id]) ok = 1'b1;
         else tick();
      end
      check(nm, ok, 1);
   endtask

   task automatic wait_result(input string nm, output int edges, output int busy_low);
      bit ok = 1'b0;
      edges = 0; busy_low = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (res_valid) ok = 1'b1;
         else begin
            if (!busy) busy_low++;
            tick();
            edges++;
         end
      end
      check(nm, ok, 1);
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic       id;
      logic [7:0] p;
   } res_t;

   initial begin
      vec_t       vecs [8];
      res_t       expq [$];
      res_t       r;
      int         edges, busy_low, clr_cnt, g, last_g, issued, done, cycles;
      logic [8:0] abits, bbits, rvbits;
      logic [1:0] gv;
      logic [3:0] op0a, op0b;
      logic [3:0] ra [2];
      logic [3:0] rb [2];
      logic [7:0] p;

      vecs[0] = '{0, 4'd3,  4'd5,  8'd15};
      vecs[1] = '{0, 4'd0,  4'd15, 8'd0};
      vecs[2] = '{0, 4'd15, 4'd1,  8'd15};
      vecs[3] = '{1, 4'd15, 4'd15, 8'd225};
      vecs[4] = '{1, 4'd7,  4'd9,  8'd63};
      vecs[5] = '{0, 4'd8,  4'd8,  8'd64};
      vecs[6] = '{1, 4'd1,  4'd1,  8'd1};
      vecs[7] = '{0, 4'd15, 4'd0,  8'd0};

      // Reset state
      do_reset();
      #1;
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_id", res_id, 0);
      check("rst_mul_clr", mul_clr, 0);
      check("rst_mul_ab", {mul_a, mul_b}, 0);
      check("rst_req_ready", req_ready, 0);

      // Single request, bit-level sequencing
      set_op(0, 4'd3, 4'd5);
      req_valid = 2'b01;
      #1;
      check("t1_req_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("t1_ready_drop", req_ready, 2'b00);
      check("t1_clr", mul_clr, 1);
      check("t1_clr_ab", {mul_a, mul_b}, 0);
      clr_cnt = 1;
      tick();
      for (int t = 0; t < 9; t++) begin
         abits[t]  = mul_a;
         bbits[t]  = mul_b;
         rvbits[t] = res_valid;
         if (mul_clr) clr_cnt++;
         tick();
      end
      check("t1_clr_pulses", clr_cnt, 1);
      check("t1_mul_a_seq", abits, 9'b000000011);
      check("t1_mul_b_seq", bbits, 9'b000000101);
      check("t1_early_valid", rvbits, 0);
      check("t1_valid_10th", res_valid, 1);
      check("t1_data", res_data, 15);
      check("t1_id", res_id, 0);
      handshake();

      // Vector table, including edge operands
      for (int i = 0; i < 8; i++) begin
         set_op(vecs[i].id, vecs[i].a, vecs[i].b);
         req_valid = (vecs[i].id == 0) ? 2'b01 : 2'b10;
         wait_ready(vecs[i].id, "vec_ready_timeout");
         check("vec_ready", req_ready, (vecs[i].id == 0) ? 2'b01 : 2'b10);
         tick();
         req_valid = 2'b00;
         wait_result("vec_result_timeout", edges, busy_low);
         check("vec_latency", edges, 10);
         check("vec_data", res_data, vecs[i].exp);
         check("vec_id", res_id, vecs[i].id);
         handshake();
         check("vec_idle", busy, 0);
      end

      // Simultaneous requests after reset
      do_reset();
      set_op(0, 4'd15, 4'd15);
      set_op(1, 4'd7, 4'd9);
      req_valid = 2'b11;
      #1;
      check("t2_first_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      check("t2_ready_busy", req_ready, 2'b00);
      wait_result("t2_r0_timeout", edges, busy_low);
      check("t2_busy0", busy_low, 0);
      check("t2_data0", res_data, 225);
      check("t2_id0", res_id, 0);
      handshake();
      #1;
      check("t2_second_grant", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      wait_result("t2_r1_timeout", edges, busy_low);
      check("t2_busy1", busy_low, 0);
      check("t2_data1", res_data, 63);
      check("t2_id1", res_id, 1);
      handshake();

      // Fairness: requester 1 always valid, requester 0 re-asserts
      do_reset();
      set_op(1, 4'd5, 4'd11);
      op0a = 4'd0; op0b = 4'd0;
      for (int k = 0; k < 4; k++) begin
         if (!req_valid[0]) begin
            op0a = 4'(k + 2);
            op0b = 4'(k + 9);
            set_op(0, op0a, op0b);
         end
         req_valid = 2'b11;
         #1;
         gv = req_ready;
         check("t3_grant", gv, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         if (gv == 2'b01) req_valid[0] = 1'b0;
         wait_result("t3_timeout", edges, busy_low);
         p = (gv == 2'b01) ? 8'(op0a) * 8'(op0b) : 8'd55;
         check("t3_data", res_data, p);
         check("t3_id", res_id, (gv == 2'b10) ? 1 : 0);
         handshake();
      end
      req_valid = 2'b00;

      // Back-pressure with a pending request
      do_reset();
      set_op(0, 4'd6, 4'd7);
      req_valid = 2'b01;
      wait_ready(0, "t4_ready_timeout");
      tick();
      set_op(1, 4'd5, 4'd5);
      req_valid = 2'b10;
      wait_result("t4_timeout", edges, busy_low);
      for (int c = 0; c < 5; c++) begin
         check("t4_hold_valid", res_valid, 1);
         check("t4_hold_data", res_data, 42);
         check("t4_hold_id", res_id, 0);
         check("t4_hold_ready", req_ready, 2'b00);
         tick();
      end
      res_ready = 1'b1;
      #1;
      check("t4_hs_ready", req_ready, 2'b00);
      tick();
      res_ready = 1'b0;
      #1;
      check("t4_next_ready", req_ready, 2'b10);
      tick();
      check("t4_next_clr", mul_clr, 1);
      req_valid = 2'b00;
      wait_result("t4_r1_timeout", edges, busy_low);
      check("t4_latency", edges, 10);
      check("t4_data1", res_data, 25);
      check("t4_id1", res_id, 1);
      handshake();

      // Reset in the middle of SHIFT
      do_reset();
      set_op(0, 4'd9, 4'd9);
      req_valid = 2'b01;
      wait_ready(0, "t5_ready_timeout");
      tick();
      req_valid = 2'b00;
      tick(); tick(); tick(); tick();
      check("t5_midop_busy", busy, 1);
      check("t5_t3_mul_a", mul_a, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_res_valid", res_valid, 0);
      check("t5_res_data", res_data, 0);
      set_op(0, 4'd2, 4'd6);
      set_op(1, 4'd3, 4'd3);
      req_valid = 2'b11;
      #1;
      check("t5_grant_after_rst", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      wait_result("t5_r0_timeout", edges, busy_low);
      check("t5_data", res_data, 12);
      check("t5_id", res_id, 0);
      handshake();
      wait_ready(1, "t5_r1_ready_timeout");
      tick();
      req_valid = 2'b00;
      wait_result("t5_r1_timeout", edges, busy_low);
      check("t5_data1", res_data, 9);
      check("t5_id1", res_id, 1);
      handshake();

      // Random traffic against a transaction-level scoreboard
      do_reset();
      last_g = 1; issued = 0; done = 0; cycles = 0;
      ra[0] = 4'd0; ra[1] = 4'd0; rb[0] = 4'd0; rb[1] = 4'd0;
      while (done < NRAND && cycles < 5000) begin
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] && issued < NRAND && $urandom_range(0, 2) == 0) begin
               ra[i] = 4'($urandom);
               rb[i] = 4'($urandom);
               set_op(i, ra[i], rb[i]);
               req_valid[i] = 1'b1;
               issued++;
            end
         end
         res_ready = 1'($urandom_range(0, 1));
         #1;
         gv = req_ready;
         if (gv != 2'b00) begin
            g = gv[1] ? 1 : 0;
            check("rnd_grant_legal", ((gv & ~req_valid) == 2'b00) && (gv != 2'b11), 1);
            check("rnd_accept_idle", expq.size(), 0);
            if (req_valid == 2'b11) check("rnd_round_robin", g, 1 - last_g);
            last_g = g;
            p = 8'(ra[g]) * 8'(rb[g]);
            expq.push_back('{1'(g), p});
         end
         if (res_valid && res_ready) begin
            if (expq.size() == 0) check("rnd_spurious_result", expq.size(), 1);
            else begin
               r = expq.pop_front();
               check("rnd_data", res_data, r.p);
               check("rnd_id", res_id, r.id);
               done++;
            end
         end
         tick();
         if (gv[0]) req_valid[0] = 1'b0;
         if (gv[1]) req_valid[1] = 1'b0;
         cycles++;
      end
      check("rnd_completed", done, NRAND);
      res_ready = 1'b0;
      req_valid = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
